// File: rtl/sdp_nrdma_lat_pkg.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_lat_pkg
// Shared types and constants for the SDP NRDMA latency-FIFO credit controller.
//   - lat_state_e : operation sequencing states
//   - lat_req_t   : DMA read request carried through the output stage
//   - SDP_NRDMA_LAT_DEPTH : latency-FIFO depth (initial / maximum credit)
// ---------------------------------------------------------------------------
package sdp_nrdma_lat_pkg;

    localparam int SDP_NRDMA_LAT_DEPTH = 160;
    localparam int SDP_NRDMA_ADDR_W    = 64;
    localparam int SDP_NRDMA_SIZE_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lat_state_e;

    typedef struct packed {
        logic [SDP_NRDMA_ADDR_W-1:0] addr;
        logic [SDP_NRDMA_SIZE_W-1:0] size;
    } lat_req_t;

endpackage

// File: rtl/sdp_nrdma_req_pipe.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_req_pipe
// Single valid/ready register stage carrying one request to the DMA port.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_req into the stage (only issued when o_free=1)
//   i_req        : request to load
//   i_rdy        : downstream ready
//   o_vld, o_req : registered request valid / payload
//   o_free       : stage can take a new request this cycle
// ---------------------------------------------------------------------------
module sdp_nrdma_req_pipe
    import sdp_nrdma_lat_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_load,
    input  lat_req_t i_req,
    input  logic     i_rdy,
    output logic     o_vld,
    output lat_req_t o_req,
    output logic     o_free
);

    logic     r_vld;
    lat_req_t r_req;

    // Payload only changes on a load, so it holds while vld & !rdy and
    // keeps the last value after the handshake completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_req <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_req <= i_req;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_req  = r_req;
    assign o_free = !r_vld || i_rdy;

endmodule

// File: rtl/sdp_nrdma_lat_credit_ctrl.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_lat_credit_ctrl
// Credit-based read-request scheduler in front of the SDP NRDMA DMA port.
// A request is admitted only when free credits cover all size+1 response
// entries it will place in the egress latency FIFO; each FIFO pop returns
// one credit. One operation is sequenced IDLE -> RUN -> DRAIN -> DONE.
//
// Optional feature macro: SDP_NRDMA_LAT_CREDIT_CHK_EN
//   defined   : err_credit is a sticky flag for a pop at full credit (with no
//               same-cycle accept) or an op_load outside IDLE
//   undefined : err_credit is tied 0
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock / async active-high reset
//   op_load, cfg_req_total          : start pulse and request count
//   src_req_*                       : upstream request (valid/ready)
//   dma_req_*                       : registered request to DMA (valid/ready)
//   lat_rd_pop                      : one latency-FIFO entry consumed
//   credit_avail                    : current free credits
//   op_busy, op_done                : state != IDLE, completion pulse
//   err_credit                      : sticky credit-accounting error
// ---------------------------------------------------------------------------
module sdp_nrdma_lat_credit_ctrl
    import sdp_nrdma_lat_pkg::*;
#(
    parameter int LAT_DEPTH = SDP_NRDMA_LAT_DEPTH,
    parameter int CRD_W     = 8,
    parameter int SIZE_W    = SDP_NRDMA_SIZE_W,
    parameter int ADDR_W    = SDP_NRDMA_ADDR_W,
    parameter int REQ_CNT_W = 16
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 op_load,
    input  logic [REQ_CNT_W-1:0] cfg_req_total,
    input  logic                 src_req_vld,
    output logic                 src_req_rdy,
    input  logic [ADDR_W-1:0]    src_req_addr,
    input  logic [SIZE_W-1:0]    src_req_size,
    output logic                 dma_req_vld,
    input  logic                 dma_req_rdy,
    output logic [ADDR_W-1:0]    dma_req_addr,
    output logic [SIZE_W-1:0]    dma_req_size,
    input  logic                 lat_rd_pop,
    output logic [CRD_W-1:0]     credit_avail,
    output logic                 op_busy,
    output logic                 op_done,
    output logic                 err_credit
);

    localparam logic [CRD_W-1:0] CRD_FULL   = CRD_W'(LAT_DEPTH);
    localparam logic [CRD_W:0]   CRD_FULL_X = (CRD_W+1)'(LAT_DEPTH);

    lat_state_e             r_state;
    lat_state_e             w_state_nxt;
    logic [CRD_W-1:0]       r_credit;
    logic [REQ_CNT_W-1:0]   r_cnt;
    logic [REQ_CNT_W-1:0]   r_total;

    logic [CRD_W-1:0]       w_need;
    logic                   w_accept;
    logic                   w_pipe_free;
    logic                   w_dma_vld;
    lat_req_t               w_src_req;
    lat_req_t               w_dma_req;
    logic [REQ_CNT_W-1:0]   w_cnt_inc;
    logic [CRD_W:0]         w_credit_sum;
    logic [CRD_W-1:0]       w_credit_nxt;
    logic                   w_load_ok;

    // need ranges 1..2^SIZE_W, never zero.
    assign w_need      = {{(CRD_W-SIZE_W){1'b0}}, src_req_size} + CRD_W'(1);
    assign src_req_rdy = (r_state == RUN) && (r_credit >= w_need) && w_pipe_free;
    assign w_accept    = src_req_vld && src_req_rdy;
    assign w_cnt_inc   = r_cnt + REQ_CNT_W'(1);
    assign w_load_ok   = (r_state == IDLE) && op_load;

    assign w_src_req.addr = src_req_addr;
    assign w_src_req.size = src_req_size;

    sdp_nrdma_req_pipe u_req_pipe (
        .i_clk  (nvdla_core_clk),
        .i_rst  (nvdla_core_rst),
        .i_load (w_accept),
        .i_req  (w_src_req),
        .i_rdy  (dma_req_rdy),
        .o_vld  (w_dma_vld),
        .o_req  (w_dma_req),
        .o_free (w_pipe_free)
    );

    assign dma_req_vld  = w_dma_vld;
    assign dma_req_addr = w_dma_req.addr;
    assign dma_req_size = w_dma_req.size;

    // Debit and return apply in the same cycle. The admission check keeps
    // the difference non-negative; one extra bit absorbs a return at full
    // credit, which then saturates back to LAT_DEPTH.
    assign w_credit_sum = {1'b0, r_credit} - {1'b0, (w_accept ? w_need : '0)}
                        + {{CRD_W{1'b0}}, lat_rd_pop};
    assign w_credit_nxt = (w_credit_sum > CRD_FULL_X) ? CRD_FULL : w_credit_sum[CRD_W-1:0];

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state  <= IDLE;
            r_credit <= CRD_FULL;
            r_cnt    <= '0;
            r_total  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            if (w_load_ok) begin
                r_cnt   <= '0;
                r_total <= cfg_req_total;
            end else if (w_accept) begin
                r_cnt   <= w_cnt_inc;
            end
        end
    end

    // RUN leaves on the accept that makes the count reach the total, so no
    // request beyond the total can be admitted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (op_load) begin
                    w_state_nxt = (cfg_req_total != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (w_accept && (w_cnt_inc == r_total)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_credit == CRD_FULL) && !w_dma_vld) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign credit_avail = r_credit;
    assign op_busy      = (r_state != IDLE);
    assign op_done      = (r_state == DONE);

`ifdef SDP_NRDMA_LAT_CREDIT_CHK_EN
    logic r_err;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_err <= 1'b0;
        end else if ((lat_rd_pop && (r_credit == CRD_FULL) && !w_accept) ||
                     (op_load && (r_state != IDLE))) begin
            r_err <= 1'b1;
        end
    end

    assign err_credit = r_err;
`else
    assign err_credit = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_nrdma_lat_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdp_nrdma_lat_credit_ctrl
// Directed bench: a table of per-cycle stimulus/expected records for one
// short operation, followed by hand-written multi-cycle sequences for credit
// exhaustion, simultaneous debit/return, backpressure, completion, zero-length
// operation with ignored load, and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_sdp_nrdma_lat_credit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [15:0] cfg_req_total = '0;
    logic        src_req_vld = 1'b0;
    logic        src_req_rdy;
    logic [63:0] src_req_addr = '0;
    logic [2:0]  src_req_size = '0;
    logic        dma_req_vld;
    logic        dma_req_rdy = 1'b0;
    logic [63:0] dma_req_addr;
    logic [2:0]  dma_req_size;
    logic        lat_rd_pop = 1'b0;
    logic [7:0]  credit_avail;
    logic        op_busy;
    logic        op_done;
    logic        err_credit;

`ifdef SDP_NRDMA_LAT_CREDIT_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sdp_nrdma_lat_credit_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .op_load        (op_load),
        .cfg_req_total  (cfg_req_total),
        .src_req_vld    (src_req_vld),
        .src_req_rdy    (src_req_rdy),
        .src_req_addr   (src_req_addr),
        .src_req_size   (src_req_size),
        .dma_req_vld    (dma_req_vld),
        .dma_req_rdy    (dma_req_rdy),
        .dma_req_addr   (dma_req_addr),
        .dma_req_size   (dma_req_size),
        .lat_rd_pop     (lat_rd_pop),
        .credit_avail   (credit_avail),
        .op_busy        (op_busy),
        .op_done        (op_done),
        .err_credit     (err_credit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        load;
        logic [15:0] total;
        logic        svld;
        logic [63:0] addr;
        logic [2:0]  size;
        logic        drdy;
        logic        pop;
        logic        e_rdy;
        logic        e_dvld;
        logic [63:0] e_addr;
        logic [2:0]  e_size;
        logic [7:0]  e_crd;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] tot, input logic sv,
                         input logic [63:0] ad, input logic [2:0] sz,
                         input logic dr, input logic pp);
        op_load       = ld;
        cfg_req_total = tot;
        src_req_vld   = sv;
        src_req_addr  = ad;
        src_req_size  = sz;
        dma_req_rdy   = dr;
        lat_rd_pop    = pp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return n credits, then expect op_done one cycle after credit is full.
    task automatic drain_and_done(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk({tag, "_crd_full"}, credit_avail, 160);
        chk({tag, "_done_pre"}, op_done, 0);
        chk({tag, "_busy_pre"}, op_busy, 1);
        tick();
        chk({tag, "_done"}, op_done, 1);
        tick();
        chk({tag, "_done_post"}, op_done, 0);
        chk({tag, "_busy_post"}, op_busy, 0);
    endtask

    initial begin
        // One short operation: 2 requests (size 3, size 0), backpressure, drain.
        tbl[0]  = '{1, 2, 0, 64'h0,    0, 1, 0,  0, 0, 64'h0,    0, 160, 0, 0};
        tbl[1]  = '{0, 0, 1, 64'h1000, 3, 1, 0,  1, 0, 64'h0,    0, 160, 1, 0};
        tbl[2]  = '{0, 0, 1, 64'h2000, 0, 0, 0,  0, 1, 64'h1000, 3, 156, 1, 0};
        tbl[3]  = '{0, 0, 1, 64'h2000, 0, 1, 0,  1, 1, 64'h1000, 3, 156, 1, 0};
        tbl[4]  = '{0, 0, 0, 64'h0,    0, 1, 1,  0, 1, 64'h2000, 0, 155, 1, 0};
        tbl[5]  = '{0, 0, 0, 64'h0,    0, 1, 1,  0, 0, 64'h2000, 0, 156, 1, 0};
        tbl[6]  = '{0, 0, 0, 64'h0,    0, 1, 1,  0, 0, 64'h2000, 0, 157, 1, 0};
        tbl[7]  = '{0, 0, 0, 64'h0,    0, 1, 1,  0, 0, 64'h2000, 0, 158, 1, 0};
        tbl[8]  = '{0, 0, 0, 64'h0,    0, 1, 1,  0, 0, 64'h2000, 0, 159, 1, 0};
        tbl[9]  = '{0, 0, 0, 64'h0,    0, 1, 0,  0, 0, 64'h2000, 0, 160, 1, 0};
        tbl[10] = '{0, 0, 0, 64'h0,    0, 1, 0,  0, 0, 64'h2000, 0, 160, 1, 1};
        tbl[11] = '{0, 0, 0, 64'h0,    0, 1, 0,  0, 0, 64'h2000, 0, 160, 0, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", src_req_rdy, 0);
        chk("rst_dvld", dma_req_vld, 0);
        chk("rst_addr", dma_req_addr, 0);
        chk("rst_size", dma_req_size, 0);
        chk("rst_crd", credit_avail, 160);
        chk("rst_busy", op_busy, 0);
        chk("rst_done", op_done, 0);
        chk("rst_err", err_credit, 0);
        rst = 1'b0;
        tick();

        // Table-driven operation
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].load, tbl[i].total, tbl[i].svld, tbl[i].addr,
                  tbl[i].size, tbl[i].drdy, tbl[i].pop);
            #1;
            chk($sformatf("tbl%0d_rdy", i),  src_req_rdy,  tbl[i].e_rdy);
            chk($sformatf("tbl%0d_dvld", i), dma_req_vld,  tbl[i].e_dvld);
            chk($sformatf("tbl%0d_addr", i), dma_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_size", i), dma_req_size, tbl[i].e_size);
            chk($sformatf("tbl%0d_crd", i),  credit_avail, tbl[i].e_crd);
            chk($sformatf("tbl%0d_busy", i), op_busy,      tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), op_done,      tbl[i].e_done);
            tick();
        end
        chk("tbl_err", err_credit, 0);

        // Credit exhaust: 20 x size 7 consume all 160 credits
        drive(1, 21, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 64'(i), 7, 1, 0);
            #1;
            chk($sformatf("exh_rdy%0d", i), src_req_rdy, 1);
            tick();
        end
        drive(0, 0, 1, 64'h5150, 7, 1, 0);
        #1;
        chk("exh_stall_rdy", src_req_rdy, 0);
        chk("exh_stall_crd", credit_avail, 0);
        tick();
        chk("exh_stall_rdy2", src_req_rdy, 0);
        chk("exh_stall_dvld", dma_req_vld, 0);
        for (int p = 0; p < 8; p++) begin
            drive(0, 0, 1, 64'h5150, 7, 1, 1);
            #1;
            chk($sformatf("exh_pop_crd%0d", p), credit_avail, 8'(p));
            chk($sformatf("exh_pop_rdy%0d", p), src_req_rdy, 0);
            tick();
        end
        drive(0, 0, 1, 64'h5150, 7, 1, 0);
        #1;
        chk("exh_resume_rdy", src_req_rdy, 1);
        chk("exh_resume_crd", credit_avail, 8);
        tick();
        chk("exh_after_dvld", dma_req_vld, 1);
        chk("exh_after_addr", dma_req_addr, 64'h5150);
        chk("exh_after_crd", credit_avail, 0);
        drain_and_done(160, "exh");

        // Simultaneous debit and return at credit 10
        drive(1, 20, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 18; i++) begin
            drive(0, 0, 1, 64'h100 + 64'(i), 7, 1, 0);
            tick();
        end
        drive(0, 0, 1, 64'h200, 5, 1, 0);
        tick();
        drive(0, 0, 1, 64'h300, 3, 1, 1);
        #1;
        chk("sim_crd10", credit_avail, 10);
        chk("sim_rdy", src_req_rdy, 1);
        tick();
        chk("sim_crd7", credit_avail, 7);
        chk("sim_size", dma_req_size, 3);
        drain_and_done(153, "sim");

        // Backpressure: first request held for 5 cycles
        drive(1, 2, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 1, 64'hAAAA, 2, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 64'hBBBB, 1, 0, 0);
            #1;
            chk($sformatf("bp_rdy%0d", i),  src_req_rdy,  0);
            chk($sformatf("bp_dvld%0d", i), dma_req_vld,  1);
            chk($sformatf("bp_addr%0d", i), dma_req_addr, 64'hAAAA);
            chk($sformatf("bp_size%0d", i), dma_req_size, 2);
            chk($sformatf("bp_crd%0d", i),  credit_avail, 157);
            tick();
        end
        drive(0, 0, 1, 64'hBBBB, 1, 1, 0);
        #1;
        chk("bp_release_rdy", src_req_rdy, 1);
        tick();
        chk("bp_next_addr", dma_req_addr, 64'hBBBB);
        chk("bp_next_size", dma_req_size, 1);
        chk("bp_next_crd", credit_avail, 155);
        drain_and_done(5, "bp");

        // Completion: 4 x size 0, pops after issue
        drive(1, 4, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 64'h40 + 64'(i), 0, 1, 0);
            tick();
        end
        chk("cmp_crd", credit_avail, 156);
        chk("cmp_rdy_drain", src_req_rdy, 0);
        drain_and_done(4, "cmp");

        // Zero-length op with an op_load while busy
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 5, 0, 0, 0, 1, 0);
        #1;
        chk("zl_busy", op_busy, 1);
        chk("zl_done_early", op_done, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("zl_done", op_done, 1);
        chk("zl_err", err_credit, ERR_EXP);
        tick();
        chk("zl_idle_busy", op_busy, 0);
        chk("zl_idle_done", op_done, 0);
        chk("zl_idle_rdy", src_req_rdy, 0);

        // Reset mid-operation with 3 requests issued
        drive(1, 5, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 64'h900 + 64'(i), 1, 1, 0);
            tick();
        end
        chk("mr_pre_crd", credit_avail, 154);
        chk("mr_pre_dvld", dma_req_vld, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rdy", src_req_rdy, 0);
        chk("mr_dvld", dma_req_vld, 0);
        chk("mr_addr", dma_req_addr, 0);
        chk("mr_size", dma_req_size, 0);
        chk("mr_crd", credit_avail, 160);
        chk("mr_busy", op_busy, 0);
        chk("mr_done", op_done, 0);
        chk("mr_err", err_credit, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_post_crd", credit_avail, 160);
        chk("mr_post_busy", op_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdp_nrdma_lat_credit_ctrl.md
# sdp_nrdma_lat_credit_ctrl

Credit-based request scheduler that sits in front of the SDP NRDMA DMA read-request port and guarantees that every outstanding read response has a reserved entry in the 160-entry egress latency FIFO. It admits a request only when free credits cover the request's full response count, returns credits as the FIFO is popped, and sequences one layer (operation) from load to drained completion.

## Interface
Parameters:
- LAT_DEPTH, 160, latency-FIFO entries (initial and maximum credit)
- CRD_W, 8, credit counter width (must hold LAT_DEPTH)
- SIZE_W, 3, request size field width; a request returns size+1 entries
- ADDR_W, 64, request address width
- REQ_CNT_W, 16, per-operation request counter width

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  asynchronous, active-high reset
- op_load  in  1  single-cycle start pulse; honoured only in IDLE
- cfg_req_total  in  REQ_CNT_W  number of requests in the operation, sampled on op_load
- src_req_vld  in  1  upstream request valid
- src_req_rdy  out  1  upstream request ready
- src_req_addr  in  ADDR_W  request address
- src_req_size  in  SIZE_W  response entries minus one
- dma_req_vld  out  1  registered request valid to DMA
- dma_req_rdy  in  1  DMA ready
- dma_req_addr  out  ADDR_W  registered address
- dma_req_size  out  SIZE_W  registered size
- lat_rd_pop  in  1  one latency-FIFO entry consumed (rd valid & rd ready)
- credit_avail  out  CRD_W  current free credits
- op_busy  out  1  state != IDLE
- op_done  out  1  single-cycle completion pulse
- err_credit  out  1  sticky credit-accounting error

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on op_load with cfg_req_total≠0; IDLE→DRAIN on op_load with cfg_req_total==0.
  - RUN→DRAIN when the accepted-request count reaches the latched total.
  - DRAIN→DONE when credit==LAT_DEPTH and dma_req_vld==0.
  - DONE→IDLE unconditionally; op_done=1 only in DONE.
  - op_load outside IDLE is ignored.
- need = src_req_size + 1 (1..2^SIZE_W), zero-extended to CRD_W.
- src_req_rdy = (state==RUN) & (credit ≥ need) & (!dma_req_vld | dma_req_rdy). This is combinational from the registered state and the output stage.
- accept = src_req_vld & src_req_rdy. On accept, the output register loads addr and size and sets dma_req_vld. The accepted count increments.
- dma_req_vld clears on dma_req_rdy without a new accept. addr and size hold while vld & !rdy.
- credit_next = credit − (accept ? need : 0) + lat_rd_pop. Simultaneous debit and return are both applied in the same cycle.
- Return when credit==LAT_DEPTH: credit saturates at LAT_DEPTH (see Configuration).
- All arithmetic is unsigned, CRD_W bits. The credit check prevents underflow by construction.
- Credits persist across operations. Credits are never reset by op_load.

## Timing
- Reset values: src_req_rdy=0, dma_req_vld=0, dma_req_addr=0, dma_req_size=0, credit_avail=LAT_DEPTH, op_busy=0, op_done=0, err_credit=0, state=IDLE, count=0.
- op_load at cycle t → op_busy=1 and src_req_rdy eligible at t+1.
- Accept at t → dma_req_vld=1 and credit_avail reduced at t+1 (1-cycle latency). Full throughput is 1 request/cycle while dma_req_rdy=1.
- lat_rd_pop at t → credit +1 visible at t+1.
- Last return brings credit to LAT_DEPTH at t with DMA stage empty → DONE at t+1 (op_done=1) → IDLE at t+2.
- Reset asserted mid-operation immediately forces all reset values. Any in-flight request on the DMA port is dropped.

## Configuration
- SDP_NRDMA_LAT_CREDIT_CHK_EN defined: err_credit is set and held until reset on either of two conditions:
  - lat_rd_pop while credit==LAT_DEPTH (and no same-cycle accept);
  - op_load while not IDLE.
- SDP_NRDMA_LAT_CREDIT_CHK_EN undefined: err_credit is tied 0 and no check logic is built. Credit saturation behaviour is identical in both builds.

## Structure
- Shared package sdp_nrdma_lat_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - SDP_NRDMA_LAT_DEPTH=160 constant;
  - request struct {addr, size}.
- One sub-module, sdp_nrdma_req_pipe: a single valid/ready register stage that carries the request struct to the DMA port. The FSM and credit counter stay in the top.

## Test plan
- Credit exhaust: 20 requests of size 7 are accepted (160 credits). The 21st stalls with src_req_rdy=0 and credit_avail=0. 8 pops later, the 21st is accepted the next cycle.
- Simultaneous: an accept of size 3 and a pop in the same cycle with credit=10 → credit_avail=7 next cycle.
- Backpressure: dma_req_rdy=0 for 5 cycles. The first request holds addr and size stable, src_req_rdy=0, and no further credit is debited.
- Completion: cfg_req_total=4, size 0 each, pops after issue → op_done pulses exactly once, 1 cycle after credit returns to 160, then op_busy=0.
- Zero-length op and ignored load: cfg_req_total=0 → done in 2 cycles. A second op_load while busy is ignored. With SDP_NRDMA_LAT_CREDIT_CHK_EN, err_credit=1.
- Reset mid-operation: assert nvdla_core_rst with 3 requests in flight → all outputs return to reset values immediately and credit_avail=160.
